// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// The arbiter is the slave side; requesters and the ALU form the master side.
interface alu_arbiter_if #(
   parameter int DW  = 32,
   parameter int OPW = 5
);
   logic           req0_valid;
   logic           req1_valid;
   logic           req0_ready;
   logic           req1_ready;
   logic [DW-1:0]  req0_a;
   logic [DW-1:0]  req0_b;
   logic [DW-1:0]  req1_a;
   logic [DW-1:0]  req1_b;
   logic [OPW-1:0] req0_op;
   logic [OPW-1:0] req1_op;
   logic           rsp0_valid;
   logic           rsp1_valid;
   logic           rsp0_ready;
   logic           rsp1_ready;
   logic [DW-1:0]  rsp_c;
   logic           rsp_zero;
   logic [DW-1:0]  alu_a;
   logic [DW-1:0]  alu_b;
   logic [OPW-1:0] alu_op;
   logic [DW-1:0]  alu_c;
   logic           alu_zero;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      input  req0_op, req1_op, rsp0_ready, rsp1_ready, alu_c, alu_zero,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_c, rsp_zero,
      output alu_a, alu_b, alu_op
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      output req0_op, req1_op, rsp0_ready, rsp1_ready, alu_c, alu_zero,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_c, rsp_zero,
      input  alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// One operation in flight: grant (IDLE) -> ALU settle (EXEC) -> hold result (RESP).
module alu_arbiter #(
   parameter int DW  = 32,
   parameter int OPW = 5
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic           prio_q, prio_d;
   logic           owner_q, owner_d;
   logic [DW-1:0]  alu_a_q, alu_a_d;
   logic [DW-1:0]  alu_b_q, alu_b_d;
   logic [OPW-1:0] alu_op_q, alu_op_d;
   logic [DW-1:0]  rsp_c_q, rsp_c_d;
   logic           rsp_zero_q, rsp_zero_d;
   logic           rsp0_valid_q, rsp0_valid_d;
   logic           rsp1_valid_q, rsp1_valid_d;
   logic           gnt_any;
   logic           gnt_id;
   logic           gnt0;
   logic           gnt1;
   logic           rsp_done;

   // Winner selection: prio only breaks ties, a lone requester always wins.
   always_comb begin
      gnt_any = bus.req0_valid | bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         gnt_id = prio_q;
      end else if (bus.req1_valid) begin
         gnt_id = 1'b1;
      end else begin
         gnt_id = 1'b0;
      end
   end

   // Only the owner's rsp_ready can complete a response.
   always_comb begin
      if (owner_q) begin
         rsp_done = bus.rsp1_ready;
      end else begin
         rsp_done = bus.rsp0_ready;
      end
   end

   // Next-state and capture logic for the three-phase operation.
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      owner_d      = owner_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_c_d      = rsp_c_q;
      rsp_zero_d   = rsp_zero_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_any && !rst) begin
               gnt0    = ~gnt_id;
               gnt1    = gnt_id;
               owner_d = gnt_id;
               prio_d  = ~gnt_id;
               state_d = EXEC;
               if (gnt_id) begin
                  alu_a_d  = bus.req1_a;
                  alu_b_d  = bus.req1_b;
                  alu_op_d = bus.req1_op;
               end else begin
                  alu_a_d  = bus.req0_a;
                  alu_b_d  = bus.req0_b;
                  alu_op_d = bus.req0_op;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            rsp_c_d      = bus.alu_c;
            rsp_zero_d   = bus.alu_zero;
            rsp0_valid_d = ~owner_q;
            rsp1_valid_d = owner_q;
            state_d      = RESP;
         end
         RESP: begin
            // No grant here even on completion; the next IDLE cycle may grant.
            if (rsp_done) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               state_d      = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            rsp0_valid_d = 1'b0;
            rsp1_valid_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         owner_q      <= 1'b0;
         alu_a_q      <= {DW{1'b0}};
         alu_b_q      <= {DW{1'b0}};
         alu_op_q     <= {OPW{1'b0}};
         rsp_c_q      <= {DW{1'b0}};
         rsp_zero_q   <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         owner_q      <= owner_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_c_q      <= rsp_c_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp_c      = rsp_c_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_op     = alu_op_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model (busy flag, age in cycles, expected result).
module tb_alu_arbiter;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_chk;
   int   cyc;

   alu_arbiter_if #(.DW(32), .OPW(5)) bus ();

   alu_arbiter #(.DW(32), .OPW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass a.
   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
      case (op)
         5'd0:    return a + b;
         5'd1:    return a - b;
         5'd2:    return a & b;
         5'd3:    return a | b;
         5'd4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   assign bus.alu_c    = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
   assign bus.alu_zero = (bus.alu_c == 32'd0);

   // Reference model state
   bit          m_busy;
   int          m_age;
   bit          m_owner;
   bit          m_prio;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [4:0]  m_op;
   logic [31:0] m_c;
   bit          m_zero;
   int          g_cyc[$];
   bit          g_id[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   function automatic logic [31:0] rnd_opnd();
      if ($urandom_range(0, 1) == 0) begin
         return 32'($urandom_range(0, 3));
      end
      return 32'($urandom);
   endfunction

   task automatic step(input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] op0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] op1,
                       input bit rr0, input bit rr1);
      bit any;
      bit gid;
      bit in_rsp;
      @(negedge clk);
      rst            = 1'b0;
      bus.req0_valid = v0;
      bus.req1_valid = v1;
      bus.req0_a     = a0;
      bus.req0_b     = b0;
      bus.req0_op    = op0;
      bus.req1_a     = a1;
      bus.req1_b     = b1;
      bus.req1_op    = op1;
      bus.rsp0_ready = rr0;
      bus.rsp1_ready = rr1;
      #1;
      any    = !m_busy && (v0 || v1);
      gid    = (v0 && v1) ? m_prio : v1;
      in_rsp = m_busy && (m_age >= 2);
      chk("req0_ready", 64'(bus.req0_ready), 64'(any && !gid));
      chk("req1_ready", 64'(bus.req1_ready), 64'(any && gid));
      chk("rsp0_valid", 64'(bus.rsp0_valid), 64'(in_rsp && !m_owner));
      chk("rsp1_valid", 64'(bus.rsp1_valid), 64'(in_rsp && m_owner));
      if (in_rsp) begin
         chk("rsp_c", 64'(bus.rsp_c), 64'(m_c));
         chk("rsp_zero", 64'(bus.rsp_zero), 64'(m_zero));
      end
      if (m_busy) begin
         chk("alu_a", 64'(bus.alu_a), 64'(m_a));
         chk("alu_b", 64'(bus.alu_b), 64'(m_b));
         chk("alu_op", 64'(bus.alu_op), 64'(m_op));
      end
      if (bus.req0_ready === 1'b1) begin
         g_cyc.push_back(cyc);
         g_id.push_back(1'b0);
      end
      if (bus.req1_ready === 1'b1) begin
         g_cyc.push_back(cyc);
         g_id.push_back(1'b1);
      end
      @(posedge clk);
      cyc++;
      if (m_busy) begin
         if (in_rsp && (m_owner ? rr1 : rr0)) m_busy = 1'b0;
         else m_age++;
      end else if (any) begin
         m_busy  = 1'b1;
         m_age   = 1;
         m_owner = gid;
         m_a     = gid ? a1 : a0;
         m_b     = gid ? b1 : b0;
         m_op    = gid ? op1 : op0;
         m_c     = alu_fn(m_a, m_b, m_op);
         m_zero  = (m_c == 32'd0);
         m_prio  = !gid;
      end
   endtask

   task automatic rnd_step(input bit v0, input bit v1, input bit rr0, input bit rr1);
      step(v0, v1, rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 5)),
           rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 5)), rr0, rr1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst            = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      chk("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
      chk("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
      chk("rst_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
      chk("rst_rsp_c", 64'(bus.rsp_c), 64'd0);
      chk("rst_rsp_zero", 64'(bus.rsp_zero), 64'd0);
      chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
      chk("rst_alu_b", 64'(bus.alu_b), 64'd0);
      chk("rst_alu_op", 64'(bus.alu_op), 64'd0);
      m_busy = 1'b0;
      m_prio = 1'b0;
      g_cyc.delete();
      g_id.delete();
   endtask

   initial begin
      n_pass = 0;
      n_chk  = 0;
      cyc    = 0;
      rst    = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_a = 32'd0;  bus.req0_b = 32'd0;  bus.req0_op = 5'd0;
      bus.req1_a = 32'd0;  bus.req1_b = 32'd0;  bus.req1_op = 5'd0;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      m_busy = 1'b0;  m_age = 0;  m_owner = 1'b0;  m_prio = 1'b0;
      m_a = 32'd0;  m_b = 32'd0;  m_op = 5'd0;  m_c = 32'd0;  m_zero = 1'b0;
      repeat (2) @(posedge clk);

      // Single request: 5 + 3
      do_reset();
      step(1'b1, 1'b0, 32'd5, 32'd3, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);

      // Contention after reset: req0 sub 7,7 then req1 or 1,2
      do_reset();
      repeat (6) step(1'b1, 1'b1, 32'd7, 32'd7, 5'd1, 32'd1, 32'd2, 5'd3, 1'b1, 1'b1);
      chk("contention_grants", 64'(g_id.size()), 64'd2);
      if (g_id.size() == 2) begin
         chk("contention_first", 64'(g_id[0]), 64'd0);
         chk("contention_second", 64'(g_id[1]), 64'd1);
      end
      repeat (2) step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);

      // Response backpressure on requester 1, rsp0_ready pulsing
      do_reset();
      step(1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd9, 32'd6, 5'd4, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'd1, 32'd1, 5'd0, 32'd1, 32'd1, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rnd_step(1'b1, 1'b1, i[0], 1'b0);
      end
      chk("backpressure_grants", 64'(g_id.size()), 64'd1);
      step(1'b1, 1'b1, 32'd2, 32'd2, 5'd0, 32'd2, 32'd2, 5'd0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 32'd2, 32'd2, 5'd0, 32'd2, 32'd2, 5'd0, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);

      // Continuous contention: 10 grants alternating, 3 cycles apart
      do_reset();
      repeat (30) rnd_step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("alt_count", 64'(g_id.size()), 64'd10);
      if (g_id.size() > 0) chk("alt_first", 64'(g_id[0]), 64'd0);
      for (int i = 1; i < g_id.size(); i++) begin
         chk("alt_id", 64'(g_id[i]), 64'(!g_id[i-1]));
         chk("alt_interval", 64'(g_cyc[i] - g_cyc[i-1]), 64'd3);
      end
      repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);

      // Reset while in EXEC: result never presented
      do_reset();
      step(1'b1, 1'b0, 32'd11, 32'd4, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
      do_reset();
      repeat (4) step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);

      // Single requester 1 repeatedly
      do_reset();
      repeat (12) rnd_step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("solo_count", 64'(g_id.size()), 64'd4);
      for (int i = 0; i < g_id.size(); i++) begin
         chk("solo_id", 64'(g_id[i]), 64'd1);
         if (i > 0) chk("solo_interval", 64'(g_cyc[i] - g_cyc[i-1]), 64'd3);
      end

      // Random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rnd_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
